// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download writer.
//   dl_entry_t   : one captured ioctl byte with its byte address
//   dl_state_t   : write sequencer states
//   GFX_BASE_DEFAULT : first ioctl byte address of the gfx region
package rom_dl_pkg;

  localparam logic [24:0] GFX_BASE_DEFAULT = 25'h10000;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  typedef enum logic {
    IDLE,
    WAIT
  } dl_state_t;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// Ports:
//   clk_sys, reset : clock, synchronous active-high reset
//   push, wdata    : write request and data; ignored while full
//   pop            : consume the head entry; ignored while empty
//   rdata          : head entry, valid whenever empty is low
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..2**AW)
module dl_fifo #(
  parameter int WIDTH = 33,
  parameter int AW    = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rom_dl_writer.sv
// Converts the ioctl download byte stream into 16-bit-lane SDRAM writes using
// toggle req/ack handshakes. CPU ROM bytes go to port1 (byte interleaved),
// gfx bytes go to port2 (two 32K planes merged into hi/lo lanes).
//
// state | meaning
// IDLE  | no write outstanding; issue the FIFO head if there is one
// WAIT  | one write outstanding on the selected port; wait for ack == req
//
// Ports:
//   clk_sys, reset        : clock, synchronous active-high reset
//   ioctl_downl/index/wr/addr/dout : download byte stream from data_io
//   port1_req/ack/a/ds/d  : CPU region SDRAM write port
//   port2_req/ack/a/ds/d  : gfx region SDRAM write port
//   busy                  : FIFO holds data or a write is outstanding
//   overflow              : sticky, a byte was dropped on a full FIFO
//   rom_loaded            : sticky, download ended and all writes acked
module rom_dl_writer
  import rom_dl_pkg::*;
#(
  parameter int          FIFO_AW   = 2,
  parameter logic [24:0] GFX_BASE  = GFX_BASE_DEFAULT,
  parameter logic [7:0]  ROM_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded
);

  dl_state_t   state;
  logic        sel_gfx;
  logic        wr_last;
  logic        downl_d;
  logic        done_pend;

  logic        push;
  logic        pop;
  dl_entry_t   fifo_in;
  logic [$bits(dl_entry_t)-1:0] fifo_head_raw;
  dl_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  logic        head_is_gfx;
  logic [24:0] gfx_off;
  logic [22:0] p1_a_nxt;
  logic [1:0]  p1_ds_nxt;
  logic [22:0] p2_a_nxt;
  logic [1:0]  p2_ds_nxt;
  logic [15:0] d_nxt;
  logic        sel_acked;
  logic        downl_rise;
  logic        downl_fall;
  logic        unused_bits;

  // Only the rising edge of the byte strobe counts, however long it is held.
  assign push    = ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index == ROM_INDEX);
  assign fifo_in = '{addr: ioctl_addr, data: ioctl_dout};
  assign pop     = (state == IDLE) & ~fifo_empty;

  dl_fifo #(
    .WIDTH($bits(dl_entry_t)),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk_sys(clk_sys),
    .reset  (reset),
    .push   (push),
    .wdata  (fifo_in),
    .pop    (pop),
    .rdata  (fifo_head_raw),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign head = dl_entry_t'(fifo_head_raw);

  // Gfx planes are 32K apart: offset bit 15 picks the lane, the bits above it
  // close up the gap so both planes share one word address.
  assign head_is_gfx = (head.addr >= GFX_BASE);
  assign gfx_off     = head.addr - GFX_BASE;
  assign p1_a_nxt    = head.addr[23:1];
  assign p1_ds_nxt   = {head.addr[0], ~head.addr[0]};
  assign p2_a_nxt    = {gfx_off[23:16], gfx_off[14:0]};
  assign p2_ds_nxt   = {~gfx_off[15], gfx_off[15]};
  assign d_nxt       = {head.data, head.data};

  assign sel_acked  = sel_gfx ? (port2_ack == port2_req) : (port1_ack == port1_req);
  assign downl_rise = ioctl_downl & ~downl_d;
  assign downl_fall = ~ioctl_downl & downl_d;

  // Bit 24 of the address space wraps silently; occupancy is not needed here.
  assign unused_bits = ^{gfx_off[24], head.addr[24], fifo_count};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      sel_gfx    <= 1'b0;
      wr_last    <= 1'b0;
      downl_d    <= 1'b0;
      done_pend  <= 1'b0;
      port1_req  <= port1_ack;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port2_req  <= port2_ack;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      wr_last <= ioctl_wr;
      downl_d <= ioctl_downl;
      busy    <= ~fifo_empty | (state == WAIT);

      if (push & fifo_full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_is_gfx) begin
              port2_a   <= p2_a_nxt;
              port2_ds  <= p2_ds_nxt;
              port2_d   <= d_nxt;
              port2_req <= ~port2_req;
              sel_gfx   <= 1'b1;
            end else begin
              port1_a   <= p1_a_nxt;
              port1_ds  <= p1_ds_nxt;
              port1_d   <= d_nxt;
              port1_req <= ~port1_req;
              sel_gfx   <= 1'b0;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (sel_acked) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new download start re-gates the core even if the previous one
      // never finished draining.
      if (downl_rise) begin
        rom_loaded <= 1'b0;
        done_pend  <= 1'b0;
      end else if (downl_fall) begin
        done_pend <= 1'b1;
      end else if (done_pend & fifo_empty & (state == IDLE)) begin
        rom_loaded <= 1'b1;
        done_pend  <= 1'b0;
      end
    end
  end

endmodule
